// File: rtl/auto_sync_ctrl.sv
// Auto-sync sequencer: arms sync_timer, sends the primary pulse train, waits for
// the measurement, retries on timeout and reports a saturated delay.
module auto_sync_ctrl #(
    parameter int PULSE_LENGTH = 3,
    parameter int PULSE_WAIT   = 5,
    parameter int PULSE_NUM    = 2,
    parameter int TIME_BITS    = 8,
    parameter int DELAY_BITS   = 12,
    parameter int DELAY_OFFSET = 4,
    parameter int RETRY_MAX    = 2,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic                   clock_det,
    input  logic                   reset_det,
    input  logic                   start,
    input  logic                   prim,
    input  logic                   abort,
    output logic                   as_en,
    output logic                   as_prim,
    input  logic                   as_done,
    input  logic                   as_timeout,
    input  logic [4*TIME_BITS-1:0] sync_time,
    output logic                   sync_out,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             retries,
    output logic [DELAY_BITS-1:0]  delay_out,
    output logic                   delay_valid
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_PULSE_HI  = 3'd2,
        S_PULSE_LO  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_EVAL      = 3'd5,
        S_GAP       = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_pulses;
    logic                  r_cap_to;
    logic [TIME_BITS-1:0]  r_cap_t1ps;
    logic                  r_as_en;
    logic                  r_sync_out;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_as_prim;
    logic                  r_error;
    logic [1:0]            r_retries;
    logic [DELAY_BITS-1:0] r_delay_out;
    logic                  r_delay_valid;
    logic                  w_as_en;
    logic                  w_sync_out;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_unused;

    // Only t1_ps feeds the delay; the other timer fields are deliberately dropped.
    assign w_unused = ^sync_time[3*TIME_BITS-1:0];
    assign w_abort  = abort && (r_state != S_IDLE);

    function automatic logic [DELAY_BITS-1:0] sat_add(input logic [TIME_BITS-1:0] t);
        logic [DELAY_BITS:0] s;
        s = (DELAY_BITS+1)'(t) + (DELAY_BITS+1)'(DELAY_OFFSET);
        if (s[DELAY_BITS]) begin
            sat_add = {DELAY_BITS{1'b1}};
        end else begin
            sat_add = s[DELAY_BITS-1:0];
        end
    endfunction

    // State register plus registered control outputs decoded from the next state.
    always_ff @(posedge clock_det or posedge reset_det) begin
        if (reset_det) begin
            r_state    <= S_IDLE;
            r_as_en    <= 1'b0;
            r_sync_out <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_as_en    <= w_as_en;
            r_sync_out <= w_sync_out;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ARM;
                else       w_next = S_IDLE;
            end
            S_ARM: begin
                if (r_as_prim) w_next = S_PULSE_HI;
                else           w_next = S_WAIT_DONE;
            end
            S_PULSE_HI: begin
                if (r_cnt == CNT_W'(PULSE_LENGTH-1)) w_next = S_PULSE_LO;
                else                                 w_next = S_PULSE_HI;
            end
            S_PULSE_LO: begin
                if (r_cnt != CNT_W'(PULSE_WAIT-1))         w_next = S_PULSE_LO;
                else if (r_pulses == CNT_W'(PULSE_NUM-1))  w_next = S_WAIT_DONE;
                else                                       w_next = S_PULSE_HI;
            end
            S_WAIT_DONE: begin
                if (as_done || (r_cnt == CNT_W'(DONE_TIMEOUT-1))) w_next = S_EVAL;
                else                                              w_next = S_WAIT_DONE;
            end
            S_EVAL: begin
                if (r_cap_to && (r_retries < 2'(RETRY_MAX))) w_next = S_GAP;
                else                                         w_next = S_FINISH;
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(1)) w_next = S_ARM;
                else                    w_next = S_GAP;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            w_next = w_next;
        end
    end

    // Output decode of the upcoming state so outputs line up with the state they belong to.
    always_comb begin
        w_as_en    = 1'b0;
        w_sync_out = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (w_next)
            S_IDLE:      w_busy = 1'b0;
            S_ARM:       begin w_as_en = 1'b1; w_busy = 1'b1; end
            S_PULSE_HI:  begin w_as_en = 1'b1; w_busy = 1'b1; w_sync_out = 1'b1; end
            S_PULSE_LO:  begin w_as_en = 1'b1; w_busy = 1'b1; end
            S_WAIT_DONE: begin w_as_en = 1'b1; w_busy = 1'b1; end
            S_EVAL:      w_busy = 1'b1;
            S_GAP:       w_busy = 1'b1;
            S_FINISH:    w_done = 1'b1;
            default:     w_busy = 1'b0;
        endcase
    end

    // Per-state cycle counter and pulse counter.
    always_ff @(posedge clock_det or posedge reset_det) begin
        if (reset_det) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_pulses <= {CNT_W{1'b0}};
        end else begin
            if (w_next != r_state) r_cnt <= {CNT_W{1'b0}};
            else                   r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == S_ARM)
                r_pulses <= {CNT_W{1'b0}};
            else if ((r_state == S_PULSE_LO) && (w_next == S_PULSE_HI))
                r_pulses <= r_pulses + CNT_W'(1);
        end
    end

    // Measurement capture and result registers exposed to the register interface.
    always_ff @(posedge clock_det or posedge reset_det) begin
        if (reset_det) begin
            r_as_prim     <= 1'b0;
            r_cap_to      <= 1'b0;
            r_cap_t1ps    <= {TIME_BITS{1'b0}};
            r_error       <= 1'b0;
            r_retries     <= 2'd0;
            r_delay_out   <= {DELAY_BITS{1'b0}};
            r_delay_valid <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_as_prim     <= prim;
            r_retries     <= 2'd0;
            r_error       <= 1'b0;
            r_delay_valid <= 1'b0;
        end else if (w_abort) begin
            r_error       <= 1'b1;
            r_delay_valid <= 1'b0;
        end else if (r_state == S_WAIT_DONE) begin
            if (as_done) begin
                r_cap_to   <= as_timeout;
                r_cap_t1ps <= sync_time[4*TIME_BITS-1:3*TIME_BITS];
            end else if (r_cnt == CNT_W'(DONE_TIMEOUT-1)) begin
                r_cap_to   <= 1'b1;
            end
        end else if (r_state == S_EVAL) begin
            if (!r_cap_to) begin
                r_delay_out   <= sat_add(r_cap_t1ps);
                r_delay_valid <= 1'b1;
                r_error       <= 1'b0;
            end else if (r_retries < 2'(RETRY_MAX)) begin
                r_retries     <= r_retries + 2'd1;
            end else begin
                r_error       <= 1'b1;
                r_delay_valid <= 1'b0;
            end
        end
    end

    assign as_en       = r_as_en;
    assign as_prim     = r_as_prim;
    assign sync_out    = r_sync_out;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign retries     = r_retries;
    assign delay_out   = r_delay_out;
    assign delay_valid = r_delay_valid;

endmodule

// File: tb/tb_auto_sync_ctrl.sv
// Directed bench for auto_sync_ctrl: stimulus pushes expected results, a monitor
// checks them when done pulses.
module tb_auto_sync_ctrl;

    logic        clock_det = 1'b0;
    logic        reset_det;
    logic        start;
    logic        prim;
    logic        abort;
    logic        as_done;
    logic        as_timeout;
    logic [31:0] sync_time;
    logic        as_en;
    logic        as_prim;
    logic        sync_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  retries;
    logic [11:0] delay_out;
    logic        delay_valid;

    auto_sync_ctrl dut (
        .clock_det(clock_det), .reset_det(reset_det), .start(start), .prim(prim),
        .abort(abort), .as_en(as_en), .as_prim(as_prim), .as_done(as_done),
        .as_timeout(as_timeout), .sync_time(sync_time), .sync_out(sync_out),
        .busy(busy), .done(done), .error(error), .retries(retries),
        .delay_out(delay_out), .delay_valid(delay_valid)
    );

    always #5 clock_det = ~clock_det;

    int cyc = 0;
    int t0 = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clock_det) cyc <= cyc + 1;

    typedef struct {
        int          rel;
        logic [11:0] d;
        logic        v;
        logic        e;
        logic [1:0]  r;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (rel cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    exp_t e;
    always @(negedge clock_det) begin
        if (!reset_det && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at rel cycle %0d, required no done", cyc - t0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc - t0, e.rel);
                check("delay_out", {20'd0, delay_out}, {20'd0, e.d});
                check("delay_valid", {31'd0, delay_valid}, {31'd0, e.v});
                check("error", {31'd0, error}, {31'd0, e.e});
                check("retries", {30'd0, retries}, {30'd0, e.r});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock_det);
        #1;
    endtask

    task automatic wait_until(input int rel);
        while (cyc - t0 < rel) tick();
    endtask

    task automatic do_start(input logic p);
        start = 1'b1;
        prim  = p;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done(input int rel, input logic to, input logic [31:0] st);
        wait_until(rel);
        as_done    = 1'b1;
        as_timeout = to;
        sync_time  = st;
        tick();
        as_done    = 1'b0;
        as_timeout = 1'b0;
    endtask

    initial begin
        reset_det  = 1'b1;
        start      = 1'b0;
        prim       = 1'b0;
        abort      = 1'b0;
        as_done    = 1'b0;
        as_timeout = 1'b0;
        sync_time  = 32'd0;
        tick();
        tick();
        check("reset_outputs",
              {13'd0, as_en, as_prim, sync_out, busy, done, error, retries, delay_out, delay_valid},
              32'd0);
        reset_det = 1'b0;
        tick();

        // Primary, good measurement; a start issued mid-run must be ignored.
        sb.push_back('{27, 12'h024, 1'b1, 1'b0, 2'd0});
        do_start(1'b1);
        for (int r = 1; r <= 24; r++) begin
            wait_until(r);
            start = (r == 5);
            prim  = 1'b0;
            check("p_as_en", {31'd0, as_en}, 32'd1);
            check("p_sync_out", {31'd0, sync_out}, {31'd0, ((r >= 2 && r <= 4) || (r >= 10 && r <= 12))});
        end
        start = 1'b0;
        check("p_as_prim", {31'd0, as_prim}, 32'd1);
        check("p_busy", {31'd0, busy}, 32'd1);
        pulse_done(25, 1'b0, 32'h20A55A77);
        check("p_eval_as_en", {31'd0, as_en}, 32'd0);
        wait_until(30);

        // Secondary: no pulses, WAIT_DONE already at cycle 2.
        sb.push_back('{4, 12'h103, 1'b1, 1'b0, 2'd0});
        do_start(1'b0);
        check("s_as_prim", {31'd0, as_prim}, 32'd0);
        check("s_sync_out", {31'd0, sync_out}, 32'd0);
        check("s_error_cleared", {31'd0, error}, 32'd0);
        pulse_done(2, 1'b0, 32'hFF112233);
        check("s_sync_out2", {31'd0, sync_out}, 32'd0);
        wait_until(6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_error", {31'd0, error}, 32'd0);
        check("idle_abort_valid", {31'd0, delay_valid}, 32'd1);

        // Retry then success.
        sb.push_back('{10, 12'h014, 1'b1, 1'b0, 2'd1});
        do_start(1'b0);
        pulse_done(2, 1'b1, 32'h99000000);
        for (int r = 3; r <= 6; r++) begin
            wait_until(r);
            check("r_as_en", {31'd0, as_en}, {31'd0, (r == 6)});
        end
        pulse_done(8, 1'b0, 32'h10000000);
        wait_until(13);

        // Exhaustion: three timed-out attempts, delay_out keeps the last good value.
        sb.push_back('{14, 12'h014, 1'b0, 1'b1, 2'd2});
        do_start(1'b0);
        pulse_done(2, 1'b1, 32'h55000000);
        pulse_done(7, 1'b1, 32'h66000000);
        pulse_done(12, 1'b1, 32'h77000000);
        wait_until(20);

        // Done timeout: as_done never arrives.
        sb.push_back('{776, 12'h014, 1'b0, 1'b1, 2'd2});
        do_start(1'b0);
        wait_until(256);
        check("t_last_wait_cycle", {31'd0, as_en}, 32'd1);
        wait_until(257);
        check("t_eval_after_255", {31'd0, as_en}, 32'd0);
        wait_until(260);
        check("t_rearm", {31'd0, as_en}, 32'd1);
        wait_until(780);

        // Start and abort together in IDLE: start wins; then abort during PULSE_HI.
        start = 1'b1;
        abort = 1'b1;
        prim  = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("a_start_wins", {30'd0, busy, as_en}, 32'd3);
        wait_until(2);
        check("a_pulse_hi", {31'd0, sync_out}, 32'd1);
        check("a_error_pre", {31'd0, error}, 32'd0);
        wait_until(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("a_outputs_off", {29'd0, sync_out, as_en, busy}, 32'd0);
        check("a_error", {31'd0, error}, 32'd1);
        check("a_valid", {31'd0, delay_valid}, 32'd0);
        wait_until(30);

        // Asynchronous reset in the middle of WAIT_DONE.
        do_start(1'b0);
        wait_until(10);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        check("rst_pre_delay", {20'd0, delay_out}, 32'h014);
        reset_det = 1'b1;
        #1;
        check("rst_async_outputs",
              {13'd0, as_en, as_prim, sync_out, busy, done, error, retries, delay_out, delay_valid},
              32'd0);
        tick();
        reset_det = 1'b0;
        tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
